right_fifo: RTL and testbench

RIGHT_FIFO -- requirements
Module: right_fifo

---
 rtl/right_fifo_pkg.sv | 10 +
 rtl/right_fifo_ram.sv | 42 ++++
 rtl/right_fifo.sv | 98 +++++++++
 tb/tb_right_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/right_fifo_pkg.sv
// Shared defaults for the right_fifo block: geometry and flag thresholds.
package right_fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH       = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH       = 24;
  localparam int unsigned DEFAULT_ALMOST_FULL_NUM  = 11;
  localparam int unsigned DEFAULT_ALMOST_EMPTY_NUM = 4;
  localparam int unsigned DEFAULT_DEPTH            = 2 ** DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/right_fifo_ram.sv
// Simple dual-port storage for right_fifo: one write port, one registered read port.
// The storage array is never reset; only the read register is.
module right_fifo_ram
  import right_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port: store the word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: load the addressed word on an accepted read, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/right_fifo.sv
// Synchronous FIFO with registered occupancy flags.
// Optional macro RIGHT_FIFO_OUT_REG_EN adds an output register after the read
// register (2-cycle read latency); flags and count are unaffected by it.
module right_fifo
  import right_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned ALMOST_FULL_NUM  = DEFAULT_ALMOST_FULL_NUM,
  parameter int unsigned ALMOST_EMPTY_NUM = DEFAULT_ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, almost_full_q, empty_q, almost_empty_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Accept decisions are made against the registered flags only.
  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  // Pointers, count and flags; flags come from the next-state count so they
  // change on the same edge as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q        <= count_d;
      full_q         <= (count_d == CNT_W'(DEPTH));
      almost_full_q  <= (count_d >= CNT_W'(ALMOST_FULL_NUM));
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= CNT_W'(ALMOST_EMPTY_NUM));
    end
  end

  right_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

`ifdef RIGHT_FIFO_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  // Output stage: free-running copy of the read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= ram_rd_data;
    end
  end

  assign rd_data = out_q;
`else
  assign rd_data = ram_rd_data;
`endif

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_right_fifo.sv
// Self-checking bench for right_fifo (default parameters). Honours
// RIGHT_FIFO_OUT_REG_EN for the expected read latency.
module tb_right_fifo;

  logic        clk_tb;
  logic        tb_rst;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        empty;
  logic        almost_empty;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected read-register contents after the latest edge, and expected rd_data.
  logic [23:0] rreg_exp;
  logic [23:0] out_exp;

  right_fifo dut (
    .clk          (clk_tb),
    .rst_n        (tb_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic        w;
    logic        r;
    logic [23:0] d;
    logic        e;
    logic        ae;
    logic        af;
    logic        f;
    logic [23:0] rreg;
  } vec_t;

  task automatic chk_flags(input string name, input logic e, input logic ae,
                           input logic af, input logic f);
    checks++;
    if ({empty, almost_empty, almost_full, full} !== {e, ae, af, f}) begin
      errors++;
      $display("FAIL %s: flags e/ae/af/f got %b%b%b%b expected %b%b%b%b", name,
               empty, almost_empty, almost_full, full, e, ae, af, f);
    end
  endtask

  task automatic chk_rd(input string name);
    checks++;
    if (rd_data !== out_exp) begin
      errors++;
      $display("FAIL %s: rd_data got %h expected %h", name, rd_data, out_exp);
    end
  endtask

  // One clock with the given inputs; new_rreg is the word the read register
  // should hold after this edge.
  task automatic tick(input logic w, input logic r, input logic [23:0] d,
                      input logic [23:0] new_rreg);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk_tb);
    #1;
`ifdef RIGHT_FIFO_OUT_REG_EN
    out_exp = rreg_exp;
`else
    out_exp = new_rreg;
`endif
    rreg_exp = new_rreg;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic do_reset();
    tb_rst = 1'b0;
    #20;
    tb_rst = 1'b1;
    rreg_exp = '0;
    out_exp  = '0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{w: 1, r: 0, d: 24'h11, e: 0, ae: 1, af: 0, f: 0, rreg: 24'h0};
    vecs[1] = '{w: 1, r: 0, d: 24'h22, e: 0, ae: 1, af: 0, f: 0, rreg: 24'h0};
    vecs[2] = '{w: 0, r: 1, d: 24'h0,  e: 0, ae: 1, af: 0, f: 0, rreg: 24'h11};
    vecs[3] = '{w: 0, r: 1, d: 24'h0,  e: 1, ae: 1, af: 0, f: 0, rreg: 24'h22};
    vecs[4] = '{w: 0, r: 1, d: 24'h0,  e: 1, ae: 1, af: 0, f: 0, rreg: 24'h22};
    // Read+write at empty: only the write lands, rd_data unchanged.
    vecs[5] = '{w: 1, r: 1, d: 24'h33, e: 0, ae: 1, af: 0, f: 0, rreg: 24'h22};
    vecs[6] = '{w: 0, r: 1, d: 24'h0,  e: 1, ae: 1, af: 0, f: 0, rreg: 24'h33};

    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = '0;
    rreg_exp = '0;
    out_exp  = '0;

    // Reset held for 200 ns.
    tb_rst = 1'b0;
    #199;
    chk_flags("reset_flags", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rd("reset_rd");
    #1;
    tb_rst = 1'b1;

    // Short directed table.
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].rreg);
      chk_flags($sformatf("vec%0d", i), vecs[i].e, vecs[i].ae, vecs[i].af, vecs[i].f);
      chk_rd($sformatf("vec%0d", i));
    end

    // Fill with 1..256.
    for (int i = 1; i <= 256; i++) begin
      tick(1'b1, 1'b0, 24'(i), rreg_exp);
      chk_flags($sformatf("fill%0d", i), 1'b0, i <= 4, i >= 11, i == 256);
    end
    tick(1'b1, 1'b0, 24'hAAAAAA, rreg_exp);
    chk_flags("fill_overflow", 1'b0, 1'b0, 1'b1, 1'b1);

    // Drain 256, in order, then one read while empty.
    for (int i = 1; i <= 256; i++) begin
      tick(1'b0, 1'b1, '0, 24'(i));
      chk_flags($sformatf("drain%0d", i), i == 256, (256 - i) <= 4, (256 - i) >= 11, 1'b0);
      chk_rd($sformatf("drain%0d", i));
    end
    tick(1'b0, 1'b1, '0, rreg_exp);
    chk_rd("drain_extra");
    tick(1'b0, 1'b0, '0, rreg_exp);
    chk_rd("drain_settle");
    chk_flags("drain_extra", 1'b1, 1'b1, 1'b0, 1'b0);

    // Read+write at full: write dropped, count 255.
    for (int i = 1; i <= 256; i++) tick(1'b1, 1'b0, 24'(i), rreg_exp);
    chk_flags("refill", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 24'hBBBBBB, 24'd1);
    chk_flags("rw_full", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 256; i++) begin
      tick(1'b0, 1'b1, '0, 24'(i));
      chk_rd($sformatf("rwf_drain%0d", i));
    end
    chk_flags("rwf_empty", 1'b1, 1'b1, 1'b0, 1'b0);

    // Read+write at count 100: count stays 100.
    for (int i = 1; i <= 100; i++) tick(1'b1, 1'b0, 24'(1000 + i), rreg_exp);
    tick(1'b1, 1'b1, 24'd5000, 24'd1001);
    chk_flags("rw_100", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      tick(1'b0, 1'b1, '0, (i == 100) ? 24'd5000 : 24'(1001 + i));
      chk_rd($sformatf("rw100_drain%0d", i));
      if (i == 99) chk_flags("rw100_99", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk_flags("rw100_empty", 1'b1, 1'b1, 1'b0, 1'b0);

    // Wrap: from a clean reset write 200, read 200, write 100, read 100.
    do_reset();
    for (int i = 1; i <= 200; i++) tick(1'b1, 1'b0, 24'(i), rreg_exp);
    for (int i = 1; i <= 200; i++) tick(1'b0, 1'b1, '0, 24'(i));
    chk_rd("wrap_first");
    for (int i = 1; i <= 100; i++) tick(1'b1, 1'b0, 24'(3000 + i), rreg_exp);
    for (int i = 1; i <= 100; i++) begin
      tick(1'b0, 1'b1, '0, 24'(3000 + i));
      chk_rd($sformatf("wrap%0d", i));
    end
    chk_flags("wrap_empty", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset with 50 words stored.
    for (int i = 1; i <= 50; i++) tick(1'b1, 1'b0, 24'(i), rreg_exp);
    tick(1'b0, 1'b1, '0, 24'd1);
    chk_flags("pre_rst", 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    tb_rst = 1'b0;
    #1;
    rreg_exp = '0;
    out_exp  = '0;
    chk_flags("async_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rd("async_rst");
    tb_rst = 1'b1;
    tick(1'b0, 1'b1, '0, rreg_exp);
    chk_flags("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rd("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
